// File: rtl/fetch_pkg.sv
// -----------------------------------------------------------------------------
// fetch_pkg
// Shared types and helpers for the instruction-fetch front end.
//   INSTR_W        : width of an instruction word
//   PC_W           : PC width of the default (RV32) configuration
//   fetch_entry_t  : {pc, instr} pair as held in the prefetch buffer
//   cnt_width()    : bits needed to count 0..depth inclusive
// -----------------------------------------------------------------------------
package fetch_pkg;

    localparam int INSTR_W = 32;
    localparam int PC_W    = 32;

    // Buffered instruction together with the address it was fetched from.
    typedef struct packed {
        logic [PC_W-1:0]    pc;
        logic [INSTR_W-1:0] instr;
    } fetch_entry_t;

    function automatic int cnt_width(input int depth);
        return $clog2(depth + 1);
    endfunction

endpackage

// File: rtl/fetch_unit_sync_fifo.sv
// -----------------------------------------------------------------------------
// sync_fifo
// Single-clock FIFO with synchronous flush and synchronous active-high reset.
// DEPTH must be a power of two so the pointers wrap naturally.
//   clk, rst     : clock and synchronous reset
//   push_i       : write push_data_i (accepted when not full, or full and popping)
//   push_data_i  : data to write
//   pop_i        : drop the head entry (ignored when empty)
//   flush_i      : empty the FIFO; overrides push and pop this cycle
//   head_o       : oldest entry (undefined when count_o == 0)
//   count_o      : number of stored entries, 0..DEPTH
// -----------------------------------------------------------------------------
module sync_fifo
    import fetch_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int DEPTH = 4
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         push_i,
    input  logic [WIDTH-1:0]             push_data_i,
    input  logic                         pop_i,
    input  logic                         flush_i,
    output logic [WIDTH-1:0]             head_o,
    output logic [cnt_width(DEPTH)-1:0]  count_o
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = cnt_width(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q;
    logic [PTR_W-1:0] rd_ptr_q;
    logic [CNT_W-1:0] count_q;
    logic             do_push;
    logic             do_pop;

    assign do_pop  = pop_i && (count_q != '0);
    assign do_push = push_i && ((count_q != CNT_W'(DEPTH)) || do_pop);

    // NOTE: state registers use non-blocking assignments so every flop samples
    // the pre-edge values of the others, independent of block ordering.
    always_ff @(posedge clk) begin
        if (rst || flush_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
            if (do_pop)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            count_q <= count_q + CNT_W'(do_push) - CNT_W'(do_pop);
        end
    end

    // NOTE: the storage array is deliberately not reset; the count and
    // pointers define which entries are meaningful, so this maps onto plain RAM.
    always_ff @(posedge clk) begin
        if (do_push && !flush_i) mem_q[wr_ptr_q] <= push_data_i;
    end

    assign head_o  = mem_q[rd_ptr_q];
    assign count_o = count_q;

endmodule

// File: rtl/fetch_unit.sv
// -----------------------------------------------------------------------------
// fetch_unit
// Decoupled prefetching instruction-fetch stage. Issues sequential word
// fetches within a credit of DEPTH (outstanding + buffered), keeps issued PCs
// in a pend queue, pairs in-order responses with them into an instr queue and
// streams {pc, instr} to decode. A redirect flushes both queues and marks all
// in-flight fetches for discard.
//   clk, rst                    : clock, synchronous active-high reset
//   imem_req_valid/ready/addr   : fetch request channel (word-aligned address)
//   imem_rsp_valid/data         : in-order response, one per accepted request
//   redirect_valid/pc           : one-cycle restart at redirect_pc & ~3
//   instr_valid/ready/data/pc   : decode stream; data and pc are 0 when idle
// -----------------------------------------------------------------------------
module fetch_unit
    import fetch_pkg::*;
#(
    parameter int              XLEN     = 32,
    parameter int              DEPTH    = 4,
    parameter logic [XLEN-1:0] RESET_PC = '0
) (
    input  logic               clk,
    input  logic               rst,
    output logic               imem_req_valid,
    input  logic               imem_req_ready,
    output logic [XLEN-1:0]    imem_req_addr,
    input  logic               imem_rsp_valid,
    input  logic [INSTR_W-1:0] imem_rsp_data,
    input  logic               redirect_valid,
    input  logic [XLEN-1:0]    redirect_pc,
    output logic               instr_valid,
    input  logic               instr_ready,
    output logic [INSTR_W-1:0] instr_data,
    output logic [XLEN-1:0]    instr_pc
);

    localparam int CNT_W = cnt_width(DEPTH);

    // Same layout as fetch_entry_t, sized by this instance's XLEN.
    typedef struct packed {
        logic [XLEN-1:0]    pc;
        logic [INSTR_W-1:0] instr;
    } entry_t;

    logic [XLEN-1:0]  fetch_pc_q, fetch_pc_d;
    logic [CNT_W-1:0] outstanding_q, outstanding_d;
    logic [CNT_W-1:0] discard_q, discard_d;

    logic [CNT_W-1:0] pend_count;
    logic [CNT_W-1:0] instr_count;
    logic [XLEN-1:0]  pend_head;
    entry_t           instr_head;
    entry_t           rsp_entry;
    logic [CNT_W:0]   in_use;
    logic             req_fire;
    logic             rsp_fire;
    logic             rsp_keep;
    logic             buf_valid;

    // Credit covers both in-flight and buffered fetches, so neither queue can overflow.
    assign in_use         = {1'b0, outstanding_q} + {1'b0, instr_count};
    assign imem_req_valid = !rst && (in_use < (CNT_W+1)'(DEPTH));
    assign imem_req_addr  = fetch_pc_q;
    assign req_fire       = imem_req_valid && imem_req_ready;

    // A response with nothing outstanding is a protocol error and is ignored.
    assign rsp_fire  = !rst && imem_rsp_valid && (outstanding_q != '0);
    assign rsp_keep  = rsp_fire && (discard_q == '0);
    assign rsp_entry = '{pc: pend_head, instr: imem_rsp_data};

    assign buf_valid   = !rst && (instr_count != '0);
    assign instr_valid = buf_valid;
    assign instr_data  = buf_valid ? instr_head.instr : '0;
    assign instr_pc    = buf_valid ? instr_head.pc    : '0;

    // NOTE: combinational next-state uses blocking assignments with every
    // output given a default first, so no path leaves a variable unassigned
    // and no latch is inferred.
    always_comb begin
        fetch_pc_d    = fetch_pc_q;
        outstanding_d = outstanding_q + CNT_W'(req_fire) - CNT_W'(rsp_fire);
        discard_d     = discard_q;

        if (req_fire) fetch_pc_d = fetch_pc_q + XLEN'(4);
        if (rsp_fire && (discard_q != '0)) discard_d = discard_q - CNT_W'(1);

        // Everything still in flight after this cycle's updates belongs to the
        // old path, including a request accepted in this very cycle.
        if (redirect_valid) begin
            fetch_pc_d = redirect_pc & ~XLEN'(3);
            discard_d  = outstanding_d;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            fetch_pc_q    <= RESET_PC;
            outstanding_q <= '0;
            discard_q     <= '0;
        end else begin
            fetch_pc_q    <= fetch_pc_d;
            outstanding_q <= outstanding_d;
            discard_q     <= discard_d;
        end
    end

    sync_fifo #(.WIDTH(XLEN), .DEPTH(DEPTH)) u_pend (
        .clk         (clk),
        .rst         (rst),
        .push_i      (req_fire && !redirect_valid),
        .push_data_i (fetch_pc_q),
        .pop_i       (rsp_keep && !redirect_valid),
        .flush_i     (redirect_valid),
        .head_o      (pend_head),
        .count_o     (pend_count)
    );

    sync_fifo #(.WIDTH($bits(entry_t)), .DEPTH(DEPTH)) u_instr (
        .clk         (clk),
        .rst         (rst),
        .push_i      (rsp_keep && !redirect_valid),
        .push_data_i (rsp_entry),
        .pop_i       (buf_valid && instr_ready),
        .flush_i     (redirect_valid),
        .head_o      (instr_head),
        .count_o     (instr_count)
    );

    // Simulation-only protocol and bookkeeping checks.
    always_ff @(posedge clk) begin
        if (!rst) begin
            assert (!(imem_rsp_valid && (outstanding_q == '0)));
            assert (pend_count == outstanding_q - discard_q);
        end
    end

endmodule

// File: tb/tb_fetch_unit.sv
// -----------------------------------------------------------------------------
// tb_fetch_unit
// Directed bench for fetch_unit (XLEN=32, DEPTH=4, RESET_PC=0). A behavioural
// memory returns each fetch address as its instruction word after mem_lat
// cycles, in order. Inputs change 1 time unit after the rising edge; outputs
// are sampled on the falling edge.
// -----------------------------------------------------------------------------
module tb_fetch_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        imem_req_valid;
    logic        imem_req_ready;
    logic [31:0] imem_req_addr;
    logic        imem_rsp_valid;
    logic [31:0] imem_rsp_data;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        instr_valid;
    logic        instr_ready;
    logic [31:0] instr_data;
    logic [31:0] instr_pc;

    int checks = 0;
    int errors = 0;
    int mem_lat;

    always #5 clk = ~clk;

    fetch_unit #(.XLEN(32), .DEPTH(4), .RESET_PC(32'h0)) dut (
        .clk            (clk),
        .rst            (rst),
        .imem_req_valid (imem_req_valid),
        .imem_req_ready (imem_req_ready),
        .imem_req_addr  (imem_req_addr),
        .imem_rsp_valid (imem_rsp_valid),
        .imem_rsp_data  (imem_rsp_data),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .instr_valid    (instr_valid),
        .instr_ready    (instr_ready),
        .instr_data     (instr_data),
        .instr_pc       (instr_pc)
    );

    // ---------------- behavioural instruction memory ----------------
    typedef struct {
        logic [31:0] addr;
        int          due;
    } mreq_t;

    mreq_t       mq[$];
    int          mcyc;
    logic        acc_s;
    logic        rst_s;
    logic [31:0] addr_s;

    initial begin
        imem_rsp_valid = 1'b0;
        imem_rsp_data  = '0;
        mcyc   = 0;
        acc_s  = 1'b0;
        rst_s  = 1'b1;
        addr_s = '0;
        forever begin
            @(negedge clk);
            acc_s  = imem_req_valid && imem_req_ready;
            addr_s = imem_req_addr;
            rst_s  = rst;
            @(posedge clk);
            #1;
            mcyc++;
            if (rst_s) begin
                mq.delete();
                imem_rsp_valid = 1'b0;
                imem_rsp_data  = '0;
            end else begin
                if (acc_s) mq.push_back('{addr: addr_s, due: mcyc - 1 + mem_lat});
                if (mq.size() > 0 && mq[0].due <= mcyc) begin
                    imem_rsp_valid = 1'b1;
                    imem_rsp_data  = mq[0].addr;
                    void'(mq.pop_front());
                end else begin
                    imem_rsp_valid = 1'b0;
                    imem_rsp_data  = '0;
                end
            end
        end
    end

    // ---------------- helpers ----------------
    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic sample();
        @(negedge clk);
    endtask

    // Holds reset for two cycles and returns at the start of the first
    // cycle with rst low (inputs for that cycle may still be changed).
    task automatic do_reset(input int lat, input logic rdy, input logic irdy);
        next_cycle();
        rst            = 1'b1;
        mem_lat        = lat;
        imem_req_ready = rdy;
        instr_ready    = irdy;
        redirect_valid = 1'b0;
        redirect_pc    = '0;
        sample();
        next_cycle();
        sample();
        next_cycle();
        rst = 1'b0;
    endtask

    initial begin
        #20000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    // ---------------- directed sequence ----------------
    initial begin
        int  n_acc;
        bit  got;

        rst            = 1'b1;
        imem_req_ready = 1'b1;
        instr_ready    = 1'b1;
        redirect_valid = 1'b0;
        redirect_pc    = '0;
        mem_lat        = 1;

        // Reset state
        next_cycle();
        sample();
        check("rst_req_valid",   imem_req_valid, 0);
        check("rst_instr_valid", instr_valid,    0);
        check("rst_instr_data",  instr_data,     0);
        check("rst_instr_pc",    instr_pc,       0);

        // 1-cycle memory, streaming at one instruction per cycle
        next_cycle();
        rst = 1'b0;
        sample();
        check("seq_first_req_valid", imem_req_valid, 1);
        check("seq_first_req_addr",  imem_req_addr,  32'h0);
        check("seq_a0_instr_valid",  instr_valid,    0);
        next_cycle();
        sample();
        check("seq_a1_req_addr",    imem_req_addr, 32'h4);
        check("seq_a1_instr_valid", instr_valid,   0);
        for (int i = 0; i < 6; i++) begin
            next_cycle();
            sample();
            check("seq_instr_valid", instr_valid,   1);
            check("seq_instr_pc",    instr_pc,      32'(4 * i));
            check("seq_instr_data",  instr_data,    32'(4 * i));
            check("seq_req_addr",    imem_req_addr, 32'(8 + 4 * i));
        end

        // Decode stalled: credit stops requests at DEPTH
        do_reset(1, 1'b1, 1'b0);
        n_acc = 0;
        for (int i = 0; i < 10; i++) begin
            if (i > 0) next_cycle();
            sample();
            if (imem_req_valid && imem_req_ready) n_acc++;
        end
        check("stall_accept_count", n_acc,          4);
        check("stall_req_valid",    imem_req_valid, 0);
        check("stall_instr_valid",  instr_valid,    1);
        check("stall_head_pc",      instr_pc,       32'h0);
        next_cycle();
        instr_ready = 1'b1;
        sample();
        check("drain_pc0", instr_pc, 32'h0);
        for (int i = 1; i < 4; i++) begin
            next_cycle();
            sample();
            check("drain_valid", instr_valid, 1);
            check("drain_pc",    instr_pc,    32'(4 * i));
            check("drain_data",  instr_data,  32'(4 * i));
        end

        // 3-cycle memory, redirect with two fetches outstanding
        do_reset(3, 1'b1, 1'b1);
        sample();
        next_cycle();
        sample();
        next_cycle();
        imem_req_ready = 1'b0;
        redirect_valid = 1'b1;
        redirect_pc    = 32'h103;
        sample();
        check("redir_held_addr", imem_req_addr, 32'h8);
        next_cycle();
        redirect_valid = 1'b0;
        imem_req_ready = 1'b1;
        sample();
        check("redir_new_req_valid", imem_req_valid, 1);
        check("redir_new_req_addr",  imem_req_addr,  32'h100);
        check("redir_t1_instr_valid", instr_valid,   0);
        for (int i = 0; i < 3; i++) begin
            next_cycle();
            sample();
            check("redir_stale_dropped", instr_valid, 0);
        end
        for (int i = 0; i < 3; i++) begin
            next_cycle();
            sample();
            check("redir_valid", instr_valid, 1);
            check("redir_pc",    instr_pc,    32'(32'h100 + 4 * i));
            check("redir_data",  instr_data,  32'(32'h100 + 4 * i));
        end

        // Redirect in the same cycle as a response, an accept and a consume
        do_reset(1, 1'b1, 1'b1);
        sample();
        next_cycle();
        sample();
        next_cycle();
        sample();
        check("coinc_pc0", instr_pc, 32'h0);
        next_cycle();
        redirect_valid = 1'b1;
        redirect_pc    = 32'h200;
        sample();
        check("coinc_pc4",      instr_pc,      32'h4);
        check("coinc_acc_addr", imem_req_addr, 32'hC);
        next_cycle();
        redirect_valid = 1'b0;
        sample();
        check("coinc_t1_instr_valid", instr_valid,   0);
        check("coinc_t1_req_addr",    imem_req_addr, 32'h200);
        next_cycle();
        sample();
        check("coinc_t2_instr_valid", instr_valid, 0);
        next_cycle();
        sample();
        check("coinc_new_valid", instr_valid, 1);
        check("coinc_new_pc",    instr_pc,    32'h200);
        next_cycle();
        sample();
        check("coinc_next_pc", instr_pc, 32'h204);

        // Redirect near the top of the address space; fetch PC wraps
        do_reset(1, 1'b1, 1'b1);
        redirect_valid = 1'b1;
        redirect_pc    = 32'hFFFF_FFFD;
        sample();
        check("wrap_t0_addr", imem_req_addr, 32'h0);
        next_cycle();
        redirect_valid = 1'b0;
        sample();
        check("wrap_addr_top",     imem_req_addr, 32'hFFFF_FFFC);
        check("wrap_t1_instr_val", instr_valid,   0);
        next_cycle();
        sample();
        check("wrap_addr_zero", imem_req_addr, 32'h0);
        next_cycle();
        sample();
        check("wrap_pc_top",   instr_pc,      32'hFFFF_FFFC);
        check("wrap_data_top", instr_data,    32'hFFFF_FFFC);
        check("wrap_addr_4",   imem_req_addr, 32'h4);
        next_cycle();
        sample();
        check("wrap_pc_zero", instr_pc, 32'h0);

        // Reset with buffered and outstanding fetches
        do_reset(3, 1'b1, 1'b0);
        sample();
        for (int i = 0; i < 4; i++) begin
            next_cycle();
            sample();
        end
        check("full_credit_req_valid", imem_req_valid, 0);
        next_cycle();
        rst = 1'b1;
        sample();
        check("midrst_req_valid",   imem_req_valid, 0);
        check("midrst_instr_valid", instr_valid,    0);
        check("midrst_instr_data",  instr_data,     0);
        check("midrst_instr_pc",    instr_pc,       0);
        next_cycle();
        sample();
        check("midrst2_instr_valid", instr_valid, 0);
        next_cycle();
        rst         = 1'b0;
        instr_ready = 1'b1;
        sample();
        check("postrst_req_valid",   imem_req_valid, 1);
        check("postrst_req_addr",    imem_req_addr,  32'h0);
        check("postrst_instr_valid", instr_valid,    0);
        got = 1'b0;
        for (int i = 0; i < 10 && !got; i++) begin
            next_cycle();
            sample();
            got = instr_valid;
        end
        check("postrst_instr_arrived", got,      1);
        check("postrst_first_pc",      instr_pc, 32'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
